// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// The transmitter imports the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_MID_TICK   = 7;
  localparam int UART_LAST_TICK  = 15;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous pad input.
// RST_VAL lets idle-high lines come out of reset without a false edge.
module bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) sync <= {STAGES{RST_VAL}};
    else     sync <= {sync[STAGES-2:0], d};
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: midpoint sampling, false-start rejection,
// framing-error and overrun flags, sticky rdy cleared by the consumer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TICK_W = $clog2(UART_OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_BITS + 1);

  logic                 rx_s;
  uart_rx_state_t       state;
  logic [TICK_W-1:0]    tick;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;

  bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
      if (rxclk_en) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              tick  <= '0;
            end
          end
          START: begin
            if (tick == TICK_W'(UART_MID_TICK)) begin
              if (!rx_s) begin
                state   <= DATA;
                tick    <= '0;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
          DATA: begin
            tick <= tick + 1'b1;
            if (tick == TICK_W'(UART_LAST_TICK)) begin
              shift   <= {rx_s, shift[DATA_BITS-1:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == IDX_W'(DATA_BITS - 1)) state <= STOP;
            end
          end
          STOP: begin
            tick <= tick + 1'b1;
            if (tick == TICK_W'(UART_LAST_TICK)) begin
              data      <= shift;
              rdy       <= 1'b1;
              frame_err <= ~rx_s;
              // A simultaneous read acknowledges the old byte, so no overrun.
              overrun   <= rdy_clr ? 1'b0 : (overrun | rdy);
              state     <= rx_s ? IDLE : WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic
// compared against a frame-level model of the receiver's visible behaviour.
module tb_uart_rx;

  localparam int BIT_CLKS = 64;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic       rxclk_en;
  logic [7:0] data;
  logic       rdy, frame_err, overrun;

  int cyc = 0;
  int vecs = 0;
  int errs = 0;

  logic [7:0] data_m = '0;
  logic       rdy_m = 1'b0, fe_m = 1'b0, ov_m = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rxclk_en = (cyc % 4 == 0);

  uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxclk_en  (rxclk_en),
    .rx        (rx),
    .rdy_clr   (rdy_clr),
    .data      (data),
    .rdy       (rdy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},      32'(data),      32'(data_m));
    check({tag, ".rdy"},       32'(rdy),       32'(rdy_m));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(fe_m));
    check({tag, ".overrun"},   32'(overrun),   32'(ov_m));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic level, input int n);
    rx = level;
    repeat (n) step();
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    step();
    rdy_clr = 1'b0;
    rdy_m = 1'b0;
    ov_m  = 1'b0;
  endtask

  // Drives one frame starting now. The byte lands when the receiver samples
  // the stop-bit midpoint: first strobe >= two sync clocks after the falling
  // edge, then 8 strobes to the start midpoint, then 9 bit periods.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic clr_at_done, input int rst_at);
    logic [9:0] bits;
    int e0, det, done_e;
    bits   = {stop, b, 1'b0};
    e0     = cyc;
    det    = ((e0 + 2 + 3) / 4) * 4;
    done_e = det + 8 * 4 + 9 * BIT_CLKS;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      rx      = bits[i / BIT_CLKS];
      rdy_clr = clr_at_done && (cyc == done_e);
      if (i == rst_at) begin
        rst = 1'b1;
        rx  = 1'b1;
        step();
        check("rst_abort.data",      32'(data),      32'(0));
        check("rst_abort.rdy",       32'(rdy),       32'(0));
        check("rst_abort.frame_err", 32'(frame_err), 32'(0));
        check("rst_abort.overrun",   32'(overrun),   32'(0));
        rst = 1'b0;
        data_m = '0; rdy_m = 1'b0; fe_m = 1'b0; ov_m = 1'b0;
        return;
      end
      step();
    end
    rdy_clr = 1'b0;
    ov_m   = clr_at_done ? 1'b0 : (ov_m | rdy_m);
    rdy_m  = 1'b1;
    data_m = b;
    fe_m   = ~stop;
  endtask

  initial begin
    logic last_stop;
    rst = 1'b1;
    repeat (3) step();
    check_all("reset");
    rst = 1'b0;
    hold(1'b1, 20);

    // back-to-back without a read: second byte overruns
    send_frame(8'h55, 1'b1, 1'b0, -1);
    check_all("b2b_first");
    send_frame(8'hA3, 1'b1, 1'b0, -1);
    check_all("b2b_second");
    pulse_clr();
    check_all("b2b_clr");

    // same pair with a read in between: no overrun
    hold(1'b1, 8);
    send_frame(8'h55, 1'b1, 1'b0, -1);
    pulse_clr();
    send_frame(8'hA3, 1'b1, 1'b0, -1);
    check_all("b2b_read_between");
    pulse_clr();

    // 4-strobe glitch must be rejected as a false start
    hold(1'b0, 16);
    hold(1'b1, 80);
    check_all("glitch");
    send_frame(8'hC6, 1'b1, 1'b0, -1);
    check_all("after_glitch");

    // read landing on the exact completion cycle
    send_frame(8'h22, 1'b1, 1'b1, -1);
    check_all("clr_at_done");
    pulse_clr();

    // break: stop low, then line held low for 3 bit times
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    check_all("break_frame");
    pulse_clr();
    hold(1'b0, 3 * BIT_CLKS);
    check_all("break_held");
    hold(1'b1, BIT_CLKS);
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    check_all("after_break");

    // reset during data bit 4, then a clean frame
    hold(1'b1, 4);
    send_frame(8'hFF, 1'b1, 1'b0, 5 * BIT_CLKS + 32);
    hold(1'b1, 40);
    check_all("post_rst_idle");
    send_frame(8'h81, 1'b1, 1'b0, -1);
    check_all("after_rst");

    // randomized traffic
    last_stop = 1'b1;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic       stop;
      int         gap;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      gap  = $urandom_range(0, 40);
      if (!last_stop && gap < 20) gap = 20;
      if (gap > 0 && $urandom_range(0, 1) == 1) begin
        rx = 1'b1;
        pulse_clr();
        gap--;
      end
      hold(1'b1, gap);
      send_frame(b, stop, ($urandom_range(0, 3) == 0), -1);
      check_all($sformatf("rand%0d", n));
      last_stop = stop;
    end
    hold(1'b1, 40);
    check_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
